// File: rtl/fp24_pkg.sv
// Shared 24-bit float format constants and accumulator FSM encoding.
// Also used by the upstream multiplier pipeline.
package fp24_pkg;

  localparam int unsigned EXP_W    = 7;
  localparam int unsigned MAN_W    = 16;
  localparam int unsigned GUARD_W  = 2;
  localparam int unsigned EXP_BIAS = 63;
  localparam int unsigned EXP_MAX  = 127;

  localparam int unsigned FLOAT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W   = 1 + MAN_W + GUARD_W;  // hidden 1 + fraction + guard
  localparam int unsigned SUM_W   = MAG_W + 1;            // room for the add carry
  localparam int unsigned LZC_W   = 5;

  localparam int unsigned SIGN_BIT = 23;
  localparam int unsigned EXP_MSB  = 22;
  localparam int unsigned EXP_LSB  = 16;
  localparam int unsigned MAN_MSB  = 15;
  localparam int unsigned MAN_LSB  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm
  } acc_state_e;

  // Magnitude as 1.m followed by zero guard bits; exp==0 encodes zero.
  function automatic logic [MAG_W-1:0] expand_mag(input logic [FLOAT_W-1:0] f);
    if (f[EXP_MSB:EXP_LSB] == '0) return '0;
    return {1'b1, f[MAN_MSB:MAN_LSB], {GUARD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp24_lzc.sv
// Combinational leading-zero counter over the 20-bit post-add magnitude.
module fp24_lzc
  import fp24_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  always_comb begin
    count = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) count = LZC_W'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/float_accumulator.sv
// Multi-cycle float accumulator: sums an operand group and emits the result on in_last.
module float_accumulator
  import fp24_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] in_float,
  input  logic               in_overflow,
  input  logic               in_underflow,
  input  logic               in_last,
  output logic               out_valid,
  output logic [FLOAT_W-1:0] out_float,
  output logic               out_overflow,
  output logic               out_underflow
);

  acc_state_e state_q, state_d;

  logic [FLOAT_W-1:0] acc_q, op_q;
  logic               last_q, sticky_ovf_q, sticky_unf_q;
  logic [MAG_W-1:0]   mag_a_q, mag_b_q;
  logic               sign_a_q, sign_b_q;
  logic [EXP_W-1:0]   exp_q;
  logic [SUM_W-1:0]   sum_q;
  logic               sign_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StAlign;
      end
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Align: the smaller-exponent magnitude is shifted right, bits past the guard are lost.
  logic [EXP_W-1:0] exp_a, exp_b, exp_diff, exp_big;
  logic [MAG_W-1:0] align_a, align_b;

  always_comb begin
    exp_a   = acc_q[EXP_MSB:EXP_LSB];
    exp_b   = op_q[EXP_MSB:EXP_LSB];
    align_a = expand_mag(acc_q);
    align_b = expand_mag(op_q);
    if (exp_a >= exp_b) begin
      exp_big  = exp_a;
      exp_diff = exp_a - exp_b;
      align_b  = (exp_diff >= EXP_W'(MAG_W)) ? '0 : align_b >> exp_diff;
    end else begin
      exp_big  = exp_b;
      exp_diff = exp_b - exp_a;
      align_a  = (exp_diff >= EXP_W'(MAG_W)) ? '0 : align_a >> exp_diff;
    end
  end

  logic [SUM_W-1:0] sum;
  logic             sum_sign;

  always_comb begin
    sum      = '0;
    sum_sign = 1'b0;
    if (sign_a_q == sign_b_q) begin
      sum      = {1'b0, mag_a_q} + {1'b0, mag_b_q};
      sum_sign = sign_a_q;
    end else if (mag_a_q > mag_b_q) begin
      sum      = {1'b0, mag_a_q - mag_b_q};
      sum_sign = sign_a_q;
    end else if (mag_b_q > mag_a_q) begin
      sum      = {1'b0, mag_b_q - mag_a_q};
      sum_sign = sign_b_q;
    end
  end

  logic [LZC_W-1:0] lzc;

  fp24_lzc u_lzc (
    .value (sum_q),
    .count (lzc)
  );

  // Normalise so the leading one sits at bit MAG_W-1, then drop the guard bits.
  logic signed [EXP_W+2:0] exp_n;
  logic [SUM_W-1:0]        shifted;
  logic [FLOAT_W-1:0]      norm_float;
  logic                    norm_ovf, norm_unf;

  always_comb begin
    shifted    = sum_q;
    exp_n      = $signed({3'b000, exp_q});
    norm_float = '0;
    norm_ovf   = 1'b0;
    norm_unf   = 1'b0;
    if (sum_q[SUM_W-1]) begin
      shifted = sum_q >> 1;
      exp_n   = exp_n + 10'sd1;
    end else if (sum_q != '0) begin
      shifted = sum_q << (lzc - 5'd1);
      exp_n   = exp_n - $signed(10'(lzc - 5'd1));
    end
    if (sum_q == '0) begin
      norm_float = '0;
    end else if (exp_n > $signed(10'(EXP_MAX))) begin
      norm_float = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      norm_ovf   = 1'b1;
    end else if (exp_n < 10'sd1) begin
      norm_unf = 1'b1;
    end else begin
      norm_float = {sign_q, exp_n[EXP_W-1:0], MAN_W'(shifted >> GUARD_W)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      op_q          <= '0;
      last_q        <= 1'b0;
      sticky_ovf_q  <= 1'b0;
      sticky_unf_q  <= 1'b0;
      mag_a_q       <= '0;
      mag_b_q       <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      exp_q         <= '0;
      sum_q         <= '0;
      sign_q        <= 1'b0;
      out_valid     <= 1'b0;
      out_float     <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q         <= in_float;
            last_q       <= in_last;
            sticky_ovf_q <= sticky_ovf_q | in_overflow;
            sticky_unf_q <= sticky_unf_q | in_underflow;
          end
        end
        StAlign: begin
          mag_a_q  <= align_a;
          mag_b_q  <= align_b;
          sign_a_q <= acc_q[SIGN_BIT];
          sign_b_q <= op_q[SIGN_BIT];
          exp_q    <= exp_big;
        end
        StAdd: begin
          sum_q  <= sum;
          sign_q <= sum_sign;
        end
        StNorm: begin
          if (last_q) begin
            out_valid     <= 1'b1;
            out_float     <= norm_float;
            out_overflow  <= sticky_ovf_q | norm_ovf;
            out_underflow <= sticky_unf_q | norm_unf;
            acc_q         <= '0;
            sticky_ovf_q  <= 1'b0;
            sticky_unf_q  <= 1'b0;
          end else begin
            acc_q        <= norm_float;
            sticky_ovf_q <= sticky_ovf_q | norm_ovf;
            sticky_unf_q <= sticky_unf_q | norm_unf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// Bench for float_accumulator: directed groups plus random groups against an integer-scaled model.
module tb_float_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_overflow, in_underflow, in_last;
  logic        out_valid, out_overflow, out_underflow;
  logic [23:0] in_float, out_float;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: running sum, sticky flags, and the last published result.
  logic [23:0] m_acc;
  bit          m_ovf, m_unf;
  logic [23:0] hold_f;
  bit          hold_o, hold_u;

  always #5 clk = ~clk;

  float_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_float      (in_float),
    .in_overflow   (in_overflow),
    .in_underflow  (in_underflow),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_float     (out_float),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Values scaled by 2^18 per unit of 1.m; the smaller operand is truncated when aligned.
  task automatic model_add(input logic [23:0] a, input logic [23:0] b,
                           output logic [23:0] r, output bit ovf, output bit unf);
    longint ma, mb, tot, mag, norm;
    int     ea, eb, emax, p, e;
    bit     neg;
    ea   = int'(a[22:16]);
    eb   = int'(b[22:16]);
    ma   = (ea == 0) ? 0 : (longint'(a[15:0]) + 65536) * 4;
    mb   = (eb == 0) ? 0 : (longint'(b[15:0]) + 65536) * 4;
    emax = (ea > eb) ? ea : eb;
    if (emax - ea >= 19) ma = 0; else ma = ma / (longint'(1) << (emax - ea));
    if (emax - eb >= 19) mb = 0; else mb = mb / (longint'(1) << (emax - eb));
    tot = (a[23] ? -ma : ma) + (b[23] ? -mb : mb);
    ovf = 0;
    unf = 0;
    r   = '0;
    if (tot != 0) begin
      neg = (tot < 0);
      mag = neg ? -tot : tot;
      p   = 0;
      for (int i = 0; i < 21; i++) if (mag >= (longint'(1) << i)) p = i;
      e    = emax + p - 18;
      norm = (p > 18) ? (mag >> (p - 18)) : (mag << (18 - p));
      if (e > 127) begin
        r   = {neg, 7'h7F, 16'hFFFF};
        ovf = 1;
      end else if (e < 1) begin
        unf = 1;
      end else begin
        r = {neg, e[6:0], norm[17:2]};
      end
    end
  endtask

  // Drives one operand, holding in_valid through the busy cycles, and checks timing and result.
  task automatic send(input logic [23:0] f, input logic ovf, input logic unf, input logic last);
    int          waited;
    logic [23:0] r;
    bit          mo, mu;
    in_valid     = 1'b1;
    in_float     = f;
    in_overflow  = ovf;
    in_underflow = unf;
    in_last      = last;
    waited       = 0;
    while (!in_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    @(posedge clk); #1;
    m_ovf |= ovf;
    m_unf |= unf;
    model_add(m_acc, f, r, mo, mu);
    m_acc = r;
    m_ovf |= mo;
    m_unf |= mu;
    for (int k = 1; k <= 3; k++) begin
      check("busy_ready", {31'd0, in_ready}, 32'd0);
      check("busy_valid", {31'd0, out_valid}, 32'd0);
      check("busy_hold", {8'd0, out_float}, {8'd0, hold_f});
      @(posedge clk); #1;
    end
    check("done_ready", {31'd0, in_ready}, 32'd1);
    check("out_valid", {31'd0, out_valid}, {31'd0, last});
    if (last) begin
      hold_f = m_acc;
      hold_o = m_ovf;
      hold_u = m_unf;
      m_acc  = '0;
      m_ovf  = 0;
      m_unf  = 0;
    end
    check("out_float", {8'd0, out_float}, {8'd0, hold_f});
    check("out_ovf", {31'd0, out_overflow}, {31'd0, hold_o});
    check("out_unf", {31'd0, out_underflow}, {31'd0, hold_u});
  endtask

  function automatic logic [23:0] rand_op();
    int         sel = $urandom_range(0, 19);
    logic [6:0] e;
    if (sel == 0)      e = 7'd0;
    else if (sel == 1) e = 7'($urandom_range(120, 127));
    else if (sel == 2) e = 7'($urandom_range(1, 6));
    else               e = 7'($urandom_range(56, 70));
    return {1'($urandom_range(0, 1)), e, 16'($urandom)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_float = '0;
    in_overflow = 1'b0; in_underflow = 1'b0; in_last = 1'b0;
    m_acc = '0; m_ovf = 0; m_unf = 0; hold_f = '0; hold_o = 0; hold_u = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_float", {8'd0, out_float}, 32'd0);
    check("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    rst = 1'b0;

    send(24'h3F0000, 0, 0, 1);
    check("t1_one", {8'd0, out_float}, 32'h3F0000);
    send(24'h3F0000, 0, 0, 0);
    send(24'h400000, 0, 0, 1);
    check("t2_three", {8'd0, out_float}, 32'h408000);
    send(24'h3F8000, 0, 0, 0);
    send(24'hBF8000, 0, 0, 1);
    check("t3_cancel", {8'd0, out_float}, 32'h000000);
    send(24'h7F8000, 0, 0, 0);
    send(24'h7F8000, 0, 0, 1);
    check("t4_sat", {8'd0, out_float}, 32'h7FFFFF);
    check("t4_ovf", {31'd0, out_overflow}, 32'd1);
    send(24'h3F0000, 0, 0, 1);
    check("t4_ovf_clr", {31'd0, out_overflow}, 32'd0);
    send(24'h3F0000, 0, 0, 0);
    send(24'h2B0000, 0, 0, 1);
    check("t5_far", {8'd0, out_float}, 32'h3F0000);
    send(24'h010000, 0, 0, 0);
    send(24'h818000, 0, 0, 1);
    check("unf_flush", {8'd0, out_float}, 32'h000000);
    check("unf_flag", {31'd0, out_underflow}, 32'd1);
    send(24'h000000, 0, 0, 1);
    check("zero_last", {8'd0, out_float}, 32'h000000);

    // Reset during ADD discards the partial sum and the held output.
    in_valid = 1'b1; in_float = 24'h3F0000; in_last = 1'b0;
    in_overflow = 1'b0; in_underflow = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("t6_ready", {31'd0, in_ready}, 32'd1);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_float", {8'd0, out_float}, 32'd0);
    m_acc = '0; m_ovf = 0; m_unf = 0; hold_f = '0; hold_o = 0; hold_u = 0;
    send(24'h3F0000, 0, 0, 1);
    check("t6_after", {8'd0, out_float}, 32'h3F0000);
    send(24'h3F0000, 0, 1, 1);
    check("t6_unf_in", {31'd0, out_underflow}, 32'd1);
    send(24'h3F0000, 0, 0, 1);
    check("t6_unf_clr", {31'd0, out_underflow}, 32'd0);

    for (int g = 0; g < 60; g++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        send(rand_op(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), (k == n - 1));
      end
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold", {8'd0, out_float}, {8'd0, hold_f});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
